guess_game_ctrl: RTL

//  Game sequencer for the number-guess design; drives the LCD string formatter.

---
 rtl/guess_game_pkg.sv | 22 ++
 rtl/guess_game_if.sv | 34 +++
 rtl/gg_btn_cond.sv | 57 +++++
 rtl/guess_game_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/guess_game_pkg.sv
// rtl/guess_game_pkg.sv - shared types and constants for the number-guess game sequencer
package guess_game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } gg_state_t;

  localparam logic [1:0] CMP_GT   = 2'd0;
  localparam logic [1:0] CMP_LT   = 2'd1;
  localparam logic [1:0] CMP_EQ   = 2'd2;
  localparam logic [1:0] CMP_NONE = 2'd3;
  localparam logic [1:0] PAGE_MAX = 2'd2;

  // Display page rotation 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_page(input logic [1:0] p);
    return (p >= PAGE_MAX) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/guess_game_if.sv
// rtl/guess_game_if.sv - board-side buttons/switches and display-side status bundle
interface guess_game_if #(
  parameter int VAL_W = 17,
  parameter int TRY_W = 4
);
  logic             set_btn;
  logic             guess_btn;
  logic             page_btn;
  logic [VAL_W-1:0] n_in;
  logic [VAL_W-1:0] m_in;
  logic [TRY_W-1:0] tries_in;

  logic [VAL_W-1:0] n_value;
  logic [VAL_W-1:0] m_value;
  logic [1:0]       cmp_out;
  logic [TRY_W-1:0] try_cnt;
  logic [TRY_W-1:0] try_limit;
  logic [1:0]       page;
  logic             playing;
  logic             win;
  logic             lose;

  // Game controller side.
  modport master (
    input  set_btn, guess_btn, page_btn, n_in, m_in, tries_in,
    output n_value, m_value, cmp_out, try_cnt, try_limit, page, playing, win, lose
  );

  // Board / display side.
  modport slave (
    output set_btn, guess_btn, page_btn, n_in, m_in, tries_in,
    input  n_value, m_value, cmp_out, try_cnt, try_limit, page, playing, win, lose
  );
endinterface

// File: rtl/gg_btn_cond.sv
// rtl/gg_btn_cond.sv - button synchroniser, optional debounce (GG_DEBOUNCE_EN), rising-edge pulse
module gg_btn_cond #(
  parameter int DB_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic s1, s2, lvl, lvl_q;

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

`ifdef GG_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYC + 1);
  logic [CW-1:0] db_cnt;
  logic          filt;

  // Filtered level follows the synced level only after DB_CYC stable clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      filt   <= 1'b0;
    end else if (s2 == filt) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DB_CYC - 1)) begin
      db_cnt <= '0;
      filt   <= s2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  // Previous level, so the pulse is combinational and lands one edge earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q <= 1'b0;
    else        lvl_q <= lvl;
  end

  assign pulse = lvl & ~lvl_q;

endmodule

// File: rtl/guess_game_ctrl.sv
// rtl/guess_game_ctrl.sv - number-guess game FSM, compare, try counter, page select; GG_DEBOUNCE_EN adds button debounce
module guess_game_ctrl
  import guess_game_pkg::*;
#(
  parameter int VAL_W  = 17,
  parameter int TRY_W  = 4,
  parameter int DB_CYC = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  guess_game_if.master gg
);

  logic set_p, guess_p, page_p;

  gg_btn_cond #(.DB_CYC(DB_CYC)) u_set   (.clk(clk), .rst_n(rst_n), .btn(gg.set_btn),   .pulse(set_p));
  gg_btn_cond #(.DB_CYC(DB_CYC)) u_guess (.clk(clk), .rst_n(rst_n), .btn(gg.guess_btn), .pulse(guess_p));
  gg_btn_cond #(.DB_CYC(DB_CYC)) u_page  (.clk(clk), .rst_n(rst_n), .btn(gg.page_btn),  .pulse(page_p));

  gg_state_t        state_q, state_d;
  logic [VAL_W-1:0] n_q, n_d, m_q, m_d;
  logic [1:0]       cmp_q, cmp_d, page_q, page_d;
  logic [TRY_W-1:0] cnt_q, cnt_d, lim_q, lim_d;
  logic             playing_q, win_q, lose_q;

  logic [1:0]       cmp_code;
  logic [TRY_W:0]   cnt_inc;

  assign cmp_code = (gg.m_in > n_q) ? CMP_GT :
                    (gg.m_in < n_q) ? CMP_LT : CMP_EQ;
  // One bit wider so the limit test cannot wrap.
  assign cnt_inc  = {1'b0, cnt_q} + 1'b1;

  // Next-state and next register values; set beats guess, terminal entry forces page 0.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    m_d     = m_q;
    cmp_d   = cmp_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    page_d  = page_p ? next_page(page_q) : page_q;
    if (set_p) begin
      if (gg.tries_in != '0) begin
        n_d     = gg.n_in;
        lim_d   = gg.tries_in;
        cnt_d   = '0;
        cmp_d   = CMP_NONE;
        m_d     = '0;
        page_d  = 2'd0;
        state_d = PLAY;
      end else begin
        state_d = IDLE;
      end
    end else if (guess_p && state_q == PLAY) begin
      m_d   = gg.m_in;
      cnt_d = cnt_inc[TRY_W-1:0];
      cmp_d = cmp_code;
      if (cmp_code == CMP_EQ) begin
        state_d = WIN;
        page_d  = 2'd0;
      end else if (cnt_inc >= {1'b0, lim_q}) begin
        state_d = LOSE;
        page_d  = 2'd0;
      end
    end
  end

  // Game registers, with status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      m_q       <= '0;
      cmp_q     <= CMP_NONE;
      cnt_q     <= '0;
      lim_q     <= '0;
      page_q    <= 2'd0;
      playing_q <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      m_q       <= m_d;
      cmp_q     <= cmp_d;
      cnt_q     <= cnt_d;
      lim_q     <= lim_d;
      page_q    <= page_d;
      playing_q <= (state_d == PLAY);
      win_q     <= (state_d == WIN);
      lose_q    <= (state_d == LOSE);
    end
  end

  assign gg.n_value   = n_q;
  assign gg.m_value   = m_q;
  assign gg.cmp_out   = cmp_q;
  assign gg.try_cnt   = cnt_q;
  assign gg.try_limit = lim_q;
  assign gg.page      = page_q;
  assign gg.playing   = playing_q;
  assign gg.win       = win_q;
  assign gg.lose      = lose_q;

endmodule
